// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module      : pc_sequencer_if
// Description : Bundle of the control, redirect and PC signals that connect
//               pc_sequencer to the hazard unit, ID resolution and PC register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if;
  logic        start_i;
  logic        hazard_i;
  logic        icache_stall_i;
  logic        dcache_stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic [31:0] pc_cur_i;
  logic [31:0] pc_next_o;
  logic        pc_enable_o;
  logic        ifid_stall_o;
  logic        ifid_flush_o;
  logic        pipe_stall_o;
  logic        redirect_pending_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] redirect_cnt_o;

  modport slave (
    input  start_i, hazard_i, icache_stall_i, dcache_stall_i,
    input  branch_i, branch_target_i, jump_i, jump_target_i, pc_cur_i,
    output pc_next_o, pc_enable_o, ifid_stall_o, ifid_flush_o, pipe_stall_o,
    output redirect_pending_o, state_o, stall_cycles_o, redirect_cnt_o
  );

  modport master (
    output start_i, hazard_i, icache_stall_i, dcache_stall_i,
    output branch_i, branch_target_i, jump_i, jump_target_i, pc_cur_i,
    input  pc_next_o, pc_enable_o, ifid_stall_o, ifid_flush_o, pipe_stall_o,
    input  redirect_pending_o, state_o, stall_cycles_o, redirect_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC controller: sequential fetch, jump/branch redirects,
//               hazard and cache-miss stalls, redirect buffering across stalls.
//               Optional performance counters enabled by PC_SEQ_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  wire logic      clk_i,
  input  wire logic      rst_i,
  pc_sequencer_if.slave  bus
);

  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] c_PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_pend_v, w_pend_v_nxt;
  logic [31:0] r_pend_tgt, w_pend_tgt_nxt;

  logic        w_redirect;
  logic [31:0] w_redirect_tgt;
  logic        w_cache_stall;
  logic        w_fetch;
  logic [31:0] w_pc_next;
  logic        w_pc_enable;
  logic        w_ifid_stall;
  logic        w_ifid_flush;
  logic        w_pipe_stall;

  assign w_redirect     = bus.jump_i | bus.branch_i;
  assign w_redirect_tgt = (bus.jump_i ? bus.jump_target_i : bus.branch_target_i) & c_ALIGN_MASK;
  assign w_cache_stall  = bus.icache_stall_i | bus.dcache_stall_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_pend_v   <= 1'b0;
      r_pend_tgt <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_v   <= w_pend_v_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pend_v_nxt   = r_pend_v;
    w_pend_tgt_nxt = r_pend_tgt;
    w_pc_next      = bus.pc_cur_i + c_PC_STEP;
    w_pc_enable    = 1'b1;
    w_ifid_stall   = 1'b0;
    w_ifid_flush   = 1'b0;
    w_pipe_stall   = 1'b0;
    w_fetch        = 1'b0;

    case (r_state)
      ST_RUN, ST_STALL: begin
        if (!bus.start_i) begin
          w_state_nxt  = ST_IDLE;
          w_pend_v_nxt = 1'b0;
          w_pc_next    = RESET_VEC;
          w_ifid_flush = 1'b1;
        end else if (w_cache_stall) begin
          w_state_nxt  = ST_STALL;
          w_pc_enable  = 1'b0;
          w_pipe_stall = 1'b1;
          w_ifid_stall = (r_state == ST_STALL);
          // The first redirect seen during a stall is the one that survives.
          if (w_redirect && !bus.hazard_i && !(r_state == ST_STALL && r_pend_v)) begin
            w_pend_v_nxt   = 1'b1;
            w_pend_tgt_nxt = w_redirect_tgt;
          end
        end else begin
          w_state_nxt = ST_RUN;
          if (r_state == ST_STALL && r_pend_v) begin
            w_pc_next    = r_pend_tgt;
            w_ifid_flush = 1'b1;
            w_pend_v_nxt = 1'b0;
          end else begin
            w_fetch = 1'b1;
          end
        end
      end
      default: begin
        w_pend_v_nxt = 1'b0;
        w_pc_next    = RESET_VEC;
        w_ifid_flush = 1'b1;
        w_state_nxt  = bus.start_i ? ST_RUN : ST_IDLE;
      end
    endcase

    // Hazard suppresses the redirect: ID re-resolves it once the stall clears.
    if (w_fetch) begin
      if (bus.hazard_i) begin
        w_pc_enable  = 1'b0;
        w_ifid_stall = 1'b1;
      end else if (w_redirect) begin
        w_pc_next    = w_redirect_tgt;
        w_ifid_flush = 1'b1;
      end
    end
  end

  assign bus.pc_next_o          = w_pc_next;
  assign bus.pc_enable_o        = w_pc_enable;
  assign bus.ifid_stall_o       = w_ifid_stall;
  assign bus.ifid_flush_o       = w_ifid_flush;
  assign bus.pipe_stall_o       = w_pipe_stall;
  assign bus.redirect_pending_o = r_pend_v;
  assign bus.state_o            = r_state;

`ifdef PC_SEQ_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_redirect_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cycles <= 32'h0;
      r_redirect_cnt <= 32'h0;
    end else if (r_state == ST_IDLE) begin
      r_stall_cycles <= 32'h0;
      r_redirect_cnt <= 32'h0;
    end else begin
      if (!w_pc_enable && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_ifid_flush && (r_redirect_cnt != 32'hFFFF_FFFF))
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles_o = r_stall_cycles;
  assign bus.redirect_cnt_o = r_redirect_cnt;
`else
  assign bus.stall_cycles_o = 32'h0;
  assign bus.redirect_cnt_o = 32'h0;
`endif

endmodule

`default_nettype wire
